// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side character buffer for the 16550 UART: 16-deep FIFO or single holding
// register, with per-character status, overrun/error flags and RDA/timeout interrupts.
module uart_rx_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int TO_TICKS = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pe_in,
  input  logic              fe_in,
  input  logic              bi_in,
  input  logic              fifo_en,
  input  logic              fifo_clr,
  input  logic [1:0]        rx_trig,
  input  logic              rd,
  input  logic              lsr_rd,
  output logic [DATA_W-1:0] dout,
  output logic              dout_pe,
  output logic              dout_fe,
  output logic              dout_bi,
  output logic [4:0]        count,
  output logic              empty,
  output logic              full,
  output logic              dr,
  output logic              oe,
  output logic              err_in_fifo,
  output logic              rda_irq,
  output logic              cti_irq
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              EW      = DATA_W + 3;
  localparam int              TW      = $clog2(TO_TICKS + 1);
  localparam logic [4:0]      DEPTH_C = 5'(DEPTH);
  localparam logic [TW-1:0]   TO_MAX  = TW'(TO_TICKS);

  function automatic logic [4:0] trig_level(input logic [1:0] sel);
    case (sel)
      2'b00:   trig_level = 5'd1;
      2'b01:   trig_level = 5'd4;
      2'b10:   trig_level = 5'd8;
      default: trig_level = 5'd14;
    endcase
  endfunction

  function automatic logic has_err(input logic [EW-1:0] e);
    has_err = |e[EW-1:DATA_W];
  endfunction

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [4:0]      err_cnt;
  logic [TW-1:0]   to_cnt;
  logic            fifo_en_q;

  logic [EW-1:0]   head;
  logic [EW-1:0]   new_entry;
  logic            flush;
  logic            rd_ok;
  logic            wr_ok;
  logic            overrun;
  logic            overwrite;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic            err_inc;
  logic            err_dec;

  assign head      = mem[rd_ptr];
  assign new_entry = {bi_in, fe_in, pe_in, din};

  assign empty = (count == 5'd0);
  assign full  = fifo_en ? (count == DEPTH_C) : (count == 5'd1);
  assign dr    = ~empty;

  // A mode change flushes exactly like fifo_clr and beats any same-cycle push/rd.
  assign flush     = fifo_clr | (fifo_en != fifo_en_q);
  assign rd_ok     = rd & ~empty & ~flush;
  assign wr_ok     = push & ~flush & (~full | rd_ok);
  assign overrun   = push & ~flush & full & ~rd_ok;
  assign overwrite = overrun & ~fifo_en;

  // Non-FIFO overwrite replaces the held entry in place, so it targets the read pointer.
  assign mem_we   = wr_ok | overwrite;
  assign mem_addr = overwrite ? rd_ptr : wr_ptr;

  assign err_inc = mem_we & has_err(new_entry);
  assign err_dec = (rd_ok | overwrite) & has_err(head);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_cnt   <= '0;
      fifo_en_q <= fifo_en;
    end else begin
      fifo_en_q <= fifo_en;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
        count   <= count + 5'(wr_ok) - 5'(rd_ok);
        err_cnt <= err_cnt + 5'(err_inc) - 5'(err_dec);
      end
    end
  end

  // Set beats clear when an overrun coincides with the LSR read.
  always_ff @(posedge clk) begin
    if (rst)          oe <= 1'b0;
    else if (overrun) oe <= 1'b1;
    else if (lsr_rd)  oe <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      to_cnt <= '0;
    else if (flush || push || rd || empty || !fifo_en)
      to_cnt <= '0;
    else if (baud_pulse && (to_cnt != TO_MAX))
      to_cnt <= to_cnt + TW'(1);
  end

  always_comb begin
    dout    = '0;
    dout_pe = 1'b0;
    dout_fe = 1'b0;
    dout_bi = 1'b0;
    if (!empty) begin
      dout    = head[DATA_W-1:0];
      dout_pe = head[DATA_W];
      dout_fe = head[DATA_W+1];
      dout_bi = head[DATA_W+2];
    end
  end

  assign err_in_fifo = (err_cnt != 5'd0);
  assign rda_irq     = fifo_en ? (count >= trig_level(rx_trig)) : (count != 5'd0);
  assign cti_irq     = fifo_en & (to_cnt == TO_MAX) & ~empty;

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Receive-side buffer controller for the UART 16550 core. It sits between the serial receiver and the register/bus interface.
- Captures each received character with its per-character status (parity, framing, break) on the receiver's one-cycle push strobe.
- Buffers characters in a 16-deep FIFO, or a single holding register in non-FIFO mode.
- Schedules the receive-data-available and character-timeout interrupts, and maintains the overrun and error-in-FIFO line-status flags.

Parameters:
DEPTH, 16, FIFO entries; power of two.
TO_TICKS, 640, baud_pulse ticks with no FIFO activity before character timeout (4 chars x 10 bits x 16).

Ports:
clk  input  1  clock, single clock domain
rst  input  1  synchronous active-high reset
baud_pulse  input  1  16x-oversample tick, one clk wide
push  input  1  receiver character-complete strobe, one clk wide
din  input  8  received character, valid with push
pe_in  input  1  parity error of char, valid with push
fe_in  input  1  framing error of char, valid with push
bi_in  input  1  break indication of char, valid with push
fifo_en  input  1  1 = 16-deep FIFO mode, 0 = single holding register
fifo_clr  input  1  one-cycle FIFO flush
rx_trig  input  2  trigger level: 00=1, 01=4, 10=8, 11=14
rd  input  1  pop strobe from bus (RBR read)
lsr_rd  input  1  LSR read strobe, clears oe
dout  output  8  head character; 0 when empty
dout_pe  output  1  head parity error; 0 when empty
dout_fe  output  1  head framing error; 0 when empty
dout_bi  output  1  head break; 0 when empty
count  output  5  entries held, 0..16
empty  output  1  count==0
full  output  1  count==DEPTH (FIFO mode) or count==1 (non-FIFO)
dr  output  1  data ready = ~empty
oe  output  1  overrun error, sticky
err_in_fifo  output  1  any stored entry has pe|fe|bi
rda_irq  output  1  received-data-available interrupt
cti_irq  output  1  character-timeout interrupt

Behaviour:
- Storage: DEPTH x 11-bit entries {bi,fe,pe,data}. Read and write pointers wrap modulo DEPTH. count is registered.
- Head outputs are first-word-fall-through, combinational from the entry at the read pointer.
- Reset (sync):
  - Pointers, count, error counter, timeout counter, oe and cti cleared.
  - All outputs 0 except empty=1.
  - Storage contents are not reset; head outputs are masked to 0 while empty.
- Push, not full: entry written, count+1. Visible on outputs the cycle after push.
- Push, full, no rd in the same cycle:
  - FIFO mode: new char discarded, FIFO unchanged, oe<=1.
  - Non-FIFO mode: holding entry overwritten with the new char, oe<=1.
- Push and rd in the same cycle:
  - Non-empty: both performed, count unchanged, no overrun even when full.
  - Empty: write only, rd ignored.
- rd when empty: ignored; no state change.
- oe:
  - Cleared by lsr_rd.
  - An overrun in the same cycle as lsr_rd leaves oe=1 (set wins).
  - Unaffected by fifo_clr.
- err_in_fifo:
  - Internal 5-bit error count: +1 on write of an entry with any status bit set, -1 on pop of such a head.
  - Non-FIFO overwrite adjusts the count for both the old and new entry.
  - err_in_fifo = (error count != 0).
- fifo_clr, or any change of fifo_en (detected against a registered copy):
  - Next cycle: pointers, count, error count, timeout counter and cti cleared.
  - Takes priority over a push or rd in the same cycle; the pushed char is lost without setting oe.
- rda_irq:
  - FIFO mode: count >= trigger level.
  - Non-FIFO mode: count >= 1.
  - Combinational from registered count; falls in the cycle after a pop drops count below the trigger.
- Timeout counter (FIFO mode only):
  - Reset to 0 on push, rd, fifo_clr, or when empty.
  - Otherwise increments on each baud_pulse, saturating at TO_TICKS.
  - cti_irq = 1 while counter == TO_TICKS and not empty.
  - Non-FIFO mode: cti_irq = 0 and the counter is held at 0.
- Inputs push/rd are assumed single-cycle strobes; a multi-cycle strobe acts once per cycle.

Test Plan:
- Reset, then 3 pushes (0x41,0x42,0x43, no errors), trig=01, fifo_en=1 -> count=3, rda_irq=0, dout=0x41; 4th push 0x44 -> rda_irq=1 next cycle; 4 rd -> dout 0x41..0x44 in order, empty=1, rda_irq=0.
- Fill 16 chars, push 17th (0x99) -> full=1, oe=1, count=16, 0x99 never read. lsr_rd -> oe=0. Push+rd on the same cycle while full -> count=16, oe stays 0.
- fifo_en=0: push 0x11 then 0x22 without rd -> count=1, dout=0x22, oe=1, cti_irq never asserts.
- Push 0x55 with fe_in=1 then 0x66 clean -> err_in_fifo=1, dout_fe=1. One rd -> dout=0x66, err_in_fifo=0.
- fifo_en=1, trig=11, push 2 chars, then 640 baud_pulses with no activity -> cti_irq=1 exactly on the 640th tick. rd -> cti_irq=0 and counter restarts.
- 5 chars stored, fifo_clr asserted with a simultaneous push -> next cycle count=0, empty=1, err_in_fifo=0, oe unchanged. Toggling fifo_en with 2 stored -> flushed likewise.
